dm_access_arbiter: RTL

- Shares the single data_memory port between two requesters: the pipeline memory stage (P) and the program/debug loader (L).
- Sequences each access as fixed ISSUE/CAPTURE phases against the synchronous memory and returns read data with a done pulse.
- Drives stall_pipe so the pipeline freezes while its access is pending.
- Sits between the EX/DM pipeline register, the loader, and data_memory.

---
 rtl/dm_access_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// dm_access_arbiter
//
// Shares the single synchronous data_memory port between the pipeline memory
// stage (P) and the program/debug loader (L). Every access runs as a fixed
// ISSUE cycle (memory enabled) followed by a CAPTURE cycle (read data comes
// back). The owner's done flop pulses, and its read data is updated, in the
// cycle after CAPTURE.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   p_req/p_rw/p_addr/p_wdata   pipeline request (held until p_done)
//   p_rdata, p_done             pipeline read data and completion pulse
//   stall_pipe                  p_req & ~p_done, freezes the pipeline
//   l_req/l_rw/l_addr/l_wdata   loader request (held until l_done)
//   l_rdata, l_done             loader read data and completion pulse
//   mem_en/mem_rw/mem_addr/mem_wdata   memory command, active in ISSUE only
//   mem_rdata                   memory read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module dm_access_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_rw,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_done,
    output logic              stall_pipe,
    input  logic              l_req,
    input  logic              l_rw,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_L = 1'b1;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state;
    logic              owner;
    logic [3:0]        starve_cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic arb_en;
    logic p_cand;
    logic l_cand;
    logic p_win;
    logic l_win;
    logic any_win;
    logic l_busy;
    logic starve_inc;

    // Arbitration: open in IDLE and CAPTURE. In CAPTURE the requester that is
    // completing is masked, so a req still high there is not mistaken for a
    // fresh request; it gets re-sampled in its done cycle instead.
    always_comb begin
        arb_en     = (state == S_IDLE) || (state == S_CAPTURE);
        p_cand     = p_req && !((state == S_CAPTURE) && (owner == OWN_P));
        l_cand     = l_req && !((state == S_CAPTURE) && (owner == OWN_L));
        l_win      = arb_en && l_cand && ((starve_cnt == STARVE_LIM) || !p_cand);
        p_win      = arb_en && p_cand && !l_win;
        any_win    = p_win || l_win;
        l_busy     = (owner == OWN_L) && ((state == S_ISSUE) || (state == S_CAPTURE));
        starve_inc = l_req && !l_busy && !l_win;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_P;
            starve_cnt <= '0;
            lat_rw     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            p_done     <= 1'b0;
            l_done     <= 1'b0;
            p_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            p_done <= 1'b0;
            l_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_win) state <= S_ISSUE;
                end
                // ISSUE -> CAPTURE: memory sees the command this cycle
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                // CAPTURE -> done: mem_rdata is valid now; writes keep old rdata
                S_CAPTURE: begin
                    state <= any_win ? S_ISSUE : S_IDLE;
                    if (owner == OWN_P) begin
                        p_done <= 1'b1;
                        if (!lat_rw) p_rdata <= mem_rdata;
                    end else begin
                        l_done <= 1'b1;
                        if (!lat_rw) l_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Winner's command is latched so requesters may change their
            // inputs freely once granted.
            if (any_win) begin
                owner     <= l_win ? OWN_L : OWN_P;
                lat_rw    <= l_win ? l_rw    : p_rw;
                lat_addr  <= l_win ? l_addr  : p_addr;
                lat_wdata <= l_win ? l_wdata : p_wdata;
            end

            if (l_win) begin
                starve_cnt <= '0;
            end else if (starve_inc && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Address/data come straight from the latches, which only change when a
    // new access is granted, so they hold their last value outside ISSUE.
    assign mem_en     = (state == S_ISSUE);
    assign mem_rw     = mem_en && lat_rw;
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign stall_pipe = p_req && !p_done;

endmodule
